// File: rtl/datapath_controller_if.sv
// Instruction/handshake and datapath control bundle between the
// sequencer (master) and the datapath side (slave).
interface datapath_controller_if;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic        err;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;
    logic        vsel;
    logic [15:0] datapath_in;

    modport master (
        input  in, load, s,
        output w, err, readnum, writenum, write,
        output loada, loadb, asel, bsel, shift,
        output ALUop, loadc, loads, vsel, datapath_in
    );

    modport slave (
        output in, load, s,
        input  w, err, readnum, writenum, write,
        input  loada, loadb, asel, bsel, shift,
        input  ALUop, loadc, loads, vsel, datapath_in
    );
endinterface

// File: rtl/datapath_controller.sv
// Multi-cycle sequencer: latches an instruction word and walks the
// datapath through read/compute/write steps, one state per clock.
module datapath_controller #(
    parameter bit IMM_SEXT = 1'b1
) (
    input logic                  clk,
    input logic                  reset_n,
    datapath_controller_if.master bus
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_CALC,
        S_WRITE_REG,
        S_WRITE_IMM
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] ir;

    logic [2:0]  opc, rn, rd, rm;
    logic [1:0]  op, sh;
    logic [7:0]  imm8;
    logic [15:0] imm_ext;

    assign opc  = ir[15:13];
    assign op   = ir[12:11];
    assign rn   = ir[10:8];
    assign rd   = ir[7:5];
    assign sh   = ir[4:3];
    assign rm   = ir[2:0];
    assign imm8 = ir[7:0];

    assign imm_ext = IMM_SEXT ? {{8{imm8[7]}}, imm8}
                              : {8'h00, imm8};

    logic is_mov_imm, is_mov_reg, is_mvn;
    logic is_add, is_cmp, is_and;

    assign is_mov_imm = (opc == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opc == 3'b110) && (op == 2'b00);
    assign is_mvn     = (opc == 3'b101) && (op == 2'b11);
    assign is_add     = (opc == 3'b101) && (op == 2'b00);
    assign is_cmp     = (opc == 3'b101) && (op == 2'b01);
    assign is_and     = (opc == 3'b101) && (op == 2'b10);

    // IR only follows load while idle, so a busy instruction stays stable
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_WAIT;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_WAIT && bus.load)
                ir <= bus.in;
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.w           = 1'b0;
        bus.err         = 1'b0;
        bus.readnum     = 3'd0;
        bus.writenum    = 3'd0;
        bus.write       = 1'b0;
        bus.loada       = 1'b0;
        bus.loadb       = 1'b0;
        bus.asel        = 1'b0;
        bus.bsel        = 1'b0;
        bus.shift       = 2'b00;
        bus.ALUop       = 2'b00;
        bus.loadc       = 1'b0;
        bus.loads       = 1'b0;
        bus.vsel        = 1'b0;
        bus.datapath_in = 16'h0000;

        unique case (state)
            S_WAIT: begin
                bus.w = 1'b1;
                if (bus.s)
                    state_nxt = S_DECODE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_mov_imm:
                        state_nxt = S_WRITE_IMM;
                    is_mov_reg, is_mvn:
                        state_nxt = S_GET_B;
                    is_add, is_cmp, is_and:
                        state_nxt = S_GET_A;
                    default: begin
                        bus.err   = 1'b1;
                        state_nxt = S_WAIT;
                    end
                endcase
            end
            S_GET_A: begin
                bus.readnum = rn;
                bus.loada   = 1'b1;
                state_nxt   = S_GET_B;
            end
            S_GET_B: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
                state_nxt   = S_CALC;
            end
            S_CALC: begin
                bus.shift = sh;
                // single-operand ops zero the A side of the ALU
                bus.asel  = is_mov_reg | is_mvn;
                bus.ALUop = is_mov_reg ? 2'b00 : op;
                if (is_cmp) begin
                    bus.loads = 1'b1;
                    state_nxt = S_WAIT;
                end else begin
                    bus.loadc = 1'b1;
                    state_nxt = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                bus.writenum = rd;
                bus.write    = 1'b1;
                state_nxt    = S_WAIT;
            end
            S_WRITE_IMM: begin
                bus.writenum    = rn;
                bus.vsel        = 1'b1;
                bus.write       = 1'b1;
                bus.datapath_in = imm_ext;
                state_nxt       = S_WAIT;
            end
            default:
                state_nxt = S_WAIT;
        endcase
    end

endmodule
